dram_model: RTL and testbench

Line-wide main-memory block sitting directly downstream of the L1 cache controller's DRAM interface. It accepts one read or write request per `dram_cs` assertion, models a fixed access latency with a down-counter, then commits the write or returns the read line and pulses `dram_ack` for exactly one cycle. It is a synthesizable backing store: cache miss refill, write-back and write-miss traffic all terminate here.

---
 rtl/dram_model_pkg.sv | 21 ++
 rtl/dram_model_if.sv | 33 +++
 rtl/dram_model_array.sv | 36 +++
 rtl/dram_model.sv | 170 +++++++++++++++++
 tb/tb_dram_model.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_model_pkg.sv
// Shared definitions for the DRAM line-store model: default widths,
// FSM state encodings and the latency-counter load helper.
package dram_model_pkg;

    localparam int unsigned DRAM_ADDR_W = 8;
    localparam int unsigned DRAM_LINE_W = 128;
    localparam int unsigned DRAM_CNT_W  = 8;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'd0,
        DRAM_BUSY = 2'd1,
        DRAM_ACK  = 2'd2,
        DRAM_TURN = 2'd3
    } dram_state_e;

    // Counter preload for a given access latency (latency is 1..255)
    function automatic logic [DRAM_CNT_W-1:0] dram_cnt_load(input int unsigned latency);
        return DRAM_CNT_W'(latency - 32'd1);
    endfunction

endpackage

// File: rtl/dram_model_if.sv
// Request/response bus between the L1 cache controller (master) and the
// DRAM line store (slave).
interface dram_model_if #(
    parameter int unsigned ADDR_W = dram_model_pkg::DRAM_ADDR_W,
    parameter int unsigned LINE_W = dram_model_pkg::DRAM_LINE_W
) ();

    logic              dram_cs;
    logic              dram_we;
    logic [ADDR_W-1:0] dram_addr;
    logic [LINE_W-1:0] dram_wdata;
    logic [LINE_W-1:0] dram_rdata;
    logic              dram_ack;

    modport master (
        output dram_cs,
        output dram_we,
        output dram_addr,
        output dram_wdata,
        input  dram_rdata,
        input  dram_ack
    );

    modport slave (
        input  dram_cs,
        input  dram_we,
        input  dram_addr,
        input  dram_wdata,
        output dram_rdata,
        output dram_ack
    );

endinterface

// File: rtl/dram_model_array.sv
// Single-port line storage: synchronous write, registered synchronous read.
// Only the read register is reset; the array contents survive reset.
module dram_model_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [LINE_W-1:0] mem [DEPTH];

    // Commit a write line
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: updates only on a read access, holds otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dram_model.sv
// Fixed-latency DRAM line store behind the L1 cache controller.
// One request per acceptance; the array access happens on the edge that
// enters ACK, and the registered dram_ack pulse follows one edge later, so
// the pulse lands LATENCY edges after acceptance and the turnaround cycle
// overlaps it.
// Optional build macro: DRAM_PROTO_CHECK_EN enables the sticky protocol
// checker on proto_err; without it proto_err is tied low.
module dram_model
    import dram_model_pkg::*;
#(
    parameter int unsigned ADDR_W  = DRAM_ADDR_W,
    parameter int unsigned LINE_W  = DRAM_LINE_W,
    parameter int unsigned LATENCY = 10
) (
    input  logic         clk,
    input  logic         rst,
    dram_model_if.slave  bus,
    output logic         proto_err
);

    localparam int unsigned           CNT_W    = DRAM_CNT_W;
    localparam logic [CNT_W-1:0]      CNT_LOAD = dram_cnt_load(LATENCY);
    localparam bit                    DIRECT   = (LATENCY == 32'd1);

    dram_state_e       state_q;
    dram_state_e       state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [LINE_W-1:0] req_wdata_q;

    logic              latch_c;
    logic              arr_en_c;
    logic              arr_we_c;
    logic [ADDR_W-1:0] arr_addr_c;
    logic [LINE_W-1:0] arr_wdata_c;
    logic              ack_set_c;

    logic              ack_q;
    logic [LINE_W-1:0] arr_rdata;

    // State, latency counter and ack pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DRAM_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            ack_q   <= ack_set_c;
        end
    end

    // Next state: accept, count down to the access edge, ack, turnaround
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            DRAM_IDLE: begin
                if (bus.dram_cs) begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = DIRECT ? DRAM_ACK : DRAM_BUSY;
                end
            end
            DRAM_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_nxt = DRAM_ACK;
                end
            end
            DRAM_ACK:  state_nxt = DRAM_TURN;
            DRAM_TURN: state_nxt = DRAM_IDLE;
            default:   state_nxt = DRAM_IDLE;
        endcase
    end

    // Outputs: request latch enable, array access and ack scheduling
    always_comb begin
        latch_c     = 1'b0;
        arr_en_c    = 1'b0;
        arr_we_c    = 1'b0;
        arr_addr_c  = req_addr_q;
        arr_wdata_c = req_wdata_q;
        ack_set_c   = (state_q == DRAM_ACK);
        unique case (state_q)
            DRAM_IDLE: begin
                if (bus.dram_cs) begin
                    latch_c = 1'b1;
                    // Single-cycle latency: the access happens on the acceptance edge
                    if (DIRECT) begin
                        arr_en_c    = 1'b1;
                        arr_we_c    = bus.dram_we;
                        arr_addr_c  = bus.dram_addr;
                        arr_wdata_c = bus.dram_wdata;
                    end
                end
            end
            DRAM_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    arr_en_c = 1'b1;
                    arr_we_c = req_we_q;
                end
            end
            default: ;
        endcase
    end

    // Request latches, loaded only at acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (latch_c) begin
            req_we_q    <= bus.dram_we;
            req_addr_q  <= bus.dram_addr;
            req_wdata_q <= bus.dram_wdata;
        end
    end

    dram_model_array #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (arr_en_c),
        .we    (arr_we_c),
        .addr  (arr_addr_c),
        .wdata (arr_wdata_c),
        .rdata (arr_rdata)
    );

    assign bus.dram_rdata = arr_rdata;
    assign bus.dram_ack   = ack_q;

`ifdef DRAM_PROTO_CHECK_EN
    logic viol_c;
    logic perr_q;

    // Master must hold cs, we and addr steady while the request is in flight
    always_comb begin
        viol_c = 1'b0;
        if ((state_q == DRAM_BUSY) || (state_q == DRAM_ACK)) begin
            viol_c = !bus.dram_cs
                  || (bus.dram_we != req_we_q)
                  || (bus.dram_addr != req_addr_q);
        end
    end

    // Sticky violation flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else if (viol_c) begin
            perr_q <= 1'b1;
        end
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_model.sv
// Self-checking bench for dram_model: a LATENCY=10 instance and a
// LATENCY=1 instance, with a scoreboard of expected ack edges and read data.
module tb_dram_model;

    localparam int unsigned AW   = 8;
    localparam int unsigned LW   = 128;
    localparam int unsigned LAT_A = 10;
    localparam int unsigned LAT_B = 1;
`ifdef DRAM_PROTO_CHECK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    typedef struct {
        logic [LW-1:0] rdata;
        int unsigned   ack_edge;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        perr_a;
    logic        perr_b;
    int unsigned cyc = 0;
    int unsigned tests_run = 0;
    int unsigned fails = 0;
    int unsigned ack_seen = 0;

    exp_t          exp_q [$];
    logic [LW-1:0] model [bit [8:0]];
    logic [LW-1:0] last_rd [2];

    dram_model_if #(.ADDR_W(AW), .LINE_W(LW)) bus_a ();
    dram_model_if #(.ADDR_W(AW), .LINE_W(LW)) bus_b ();

    dram_model #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(LAT_A)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_a),
        .proto_err (perr_a)
    );

    dram_model #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(LAT_B)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_b),
        .proto_err (perr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic ack_of(input bit sel);
        return sel ? bus_b.dram_ack : bus_a.dram_ack;
    endfunction

    function automatic logic [LW-1:0] rd_of(input bit sel);
        return sel ? bus_b.dram_rdata : bus_a.dram_rdata;
    endfunction

    // Present a request (call at a negedge) and push its expected outcome
    task automatic drive_req(input bit sel, input bit we, input logic [AW-1:0] addr,
                             input logic [LW-1:0] wdata, input bit in_turn);
        exp_t        e;
        int unsigned e0;
        e0 = cyc + (in_turn ? 32'd2 : 32'd1);
        e.ack_edge = e0 + (sel ? LAT_B : LAT_A);
        if (we) begin
            e.rdata = last_rd[sel];
            model[{sel, addr}] = wdata;
        end else begin
            e.rdata = model[{sel, addr}];
            last_rd[sel] = e.rdata;
        end
        exp_q.push_back(e);
        if (sel) begin
            bus_b.dram_cs = 1'b1; bus_b.dram_we = we;
            bus_b.dram_addr = addr; bus_b.dram_wdata = wdata;
        end else begin
            bus_a.dram_cs = 1'b1; bus_a.dram_we = we;
            bus_a.dram_addr = addr; bus_a.dram_wdata = wdata;
        end
    endtask

    // Wait (bounded) for the ack, pop the scoreboard and compare; returns at the ack negedge
    task automatic wait_ack(input bit sel, input string name);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ack_of(sel) === 1'b1) got = 1'b1;
        end
        tests_run++;
        if (!got || exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: no ack (got=%0d, queued=%0d)", name, got, exp_q.size());
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            ack_seen = cyc;
            if (cyc !== e.ack_edge) begin
                fails++;
                $display("FAIL %s_edge: ack at edge %0d, want %0d", name, cyc, e.ack_edge);
            end
            tests_run++;
            if (rd_of(sel) !== e.rdata) begin
                fails++;
                $display("FAIL %s_data: rdata %h, want %h", name, rd_of(sel), e.rdata);
            end
        end
    endtask

    task automatic idle(input bit sel);
        if (sel) bus_b.dram_cs = 1'b0;
        else     bus_a.dram_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus_a.dram_ack, bus_b.dram_ack, perr_a, perr_b} !== 4'b0 ||
            bus_a.dram_rdata !== '0 || bus_b.dram_rdata !== '0) begin
            fails++;
            $display("FAIL reset_values: ack %b/%b perr %b/%b rdata %h/%h, want all 0",
                     bus_a.dram_ack, bus_b.dram_ack, perr_a, perr_b, bus_a.dram_rdata, bus_b.dram_rdata);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus_a.dram_ack, perr_a} !== 2'b0 || bus_a.dram_rdata !== '0) begin
                fails++;
                $display("FAIL idle_%0d: ack %b perr %b rdata %h, want 0", i,
                         bus_a.dram_ack, perr_a, bus_a.dram_rdata);
            end
        end
    endtask

    task automatic test_write_read();
        logic [AW-1:0] ta [3];
        logic [LW-1:0] td [3];
        int unsigned   e_w;
        ta[0] = 8'h00; td[0] = {4{32'hA5A5_5A5A}};
        ta[1] = 8'hFF; td[1] = {4{32'hFFFF_FFFF}};
        ta[2] = 8'h5A; td[2] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        drive_req(1'b0, 1'b1, 8'h05, 128'hDEADBEEF_00000001_CAFEF00D_12345678, 1'b0);
        wait_ack(1'b0, "wr05");
        e_w = ack_seen;
        drive_req(1'b0, 1'b0, 8'h05, '0, 1'b1);
        wait_ack(1'b0, "rd05");
        tests_run++;
        if (ack_seen - e_w !== 32'd12) begin
            fails++;
            $display("FAIL wr_rd_spacing: %0d cycles, want 12", ack_seen - e_w);
        end
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, 1'b1, ta[i], td[i], 1'b1);
            wait_ack(1'b0, "wr_tab");
        end
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, 1'b0, ta[i], '0, 1'b1);
            wait_ack(1'b0, "rd_tab");
        end
        idle(1'b0);
    endtask

    task automatic test_lat1();
        int unsigned e1;
        drive_req(1'b1, 1'b1, 8'h03, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
        wait_ack(1'b1, "l1_wr");
        idle(1'b1);
        drive_req(1'b1, 1'b0, 8'h03, '0, 1'b0);
        wait_ack(1'b1, "l1_rd_a");
        e1 = ack_seen;
        drive_req(1'b1, 1'b0, 8'h03, '0, 1'b1);
        wait_ack(1'b1, "l1_rd_b");
        tests_run++;
        if (ack_seen - e1 !== 32'd3) begin
            fails++;
            $display("FAIL l1_spacing: %0d cycles, want 3", ack_seen - e1);
        end
        idle(1'b1);
    endtask

    task automatic test_reset_abort();
        logic [LW-1:0] p;
        bit            acked;
        p = 128'hC0FF_EE00_1234_5678_9ABC_DEF0_0BAD_F00D;
        drive_req(1'b0, 1'b1, 8'h10, p, 1'b0);
        wait_ack(1'b0, "pre_wr10");
        idle(1'b0);
        bus_a.dram_cs = 1'b1; bus_a.dram_we = 1'b1;
        bus_a.dram_addr = 8'h10; bus_a.dram_wdata = ~p;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        bus_a.dram_cs = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus_a.dram_ack !== 1'b0 || bus_a.dram_rdata !== '0 || perr_a !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: ack %b rdata %h perr %b, want 0",
                     bus_a.dram_ack, bus_a.dram_rdata, perr_a);
        end
        rst = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        acked = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus_a.dram_ack === 1'b1) acked = 1'b1;
        end
        tests_run++;
        if (acked) begin
            fails++;
            $display("FAIL abort_no_ack: ack seen %b, want 0", acked);
        end
        drive_req(1'b0, 1'b0, 8'h10, '0, 1'b0);
        wait_ack(1'b0, "rd10_after_abort");
        idle(1'b0);
    endtask

    task automatic test_back_to_back();
        int unsigned e_w;
        drive_req(1'b0, 1'b1, 8'h21, 128'h2121_2121_0000_FFFF_1357_9BDF_2468_ACE0, 1'b0);
        wait_ack(1'b0, "pre_wr21");
        idle(1'b0);
        drive_req(1'b0, 1'b1, 8'h20, 128'h2020_2020_DEAD_0000_BEEF_0000_FACE_0000, 1'b0);
        wait_ack(1'b0, "wb_wr20");
        e_w = ack_seen;
        drive_req(1'b0, 1'b0, 8'h21, '0, 1'b1);
        wait_ack(1'b0, "miss_rd21");
        tests_run++;
        if (ack_seen - e_w !== LAT_A + 32'd2) begin
            fails++;
            $display("FAIL b2b_spacing: %0d cycles, want %0d", ack_seen - e_w, LAT_A + 2);
        end
        idle(1'b0);
    endtask

    task automatic test_proto();
        tests_run++;
        if (perr_a !== 1'b0 || perr_b !== 1'b0) begin
            fails++;
            $display("FAIL perr_clean: proto_err %b/%b, want 0", perr_a, perr_b);
        end
        drive_req(1'b0, 1'b0, 8'h05, '0, 1'b0);
        repeat (3) @(negedge clk);
        bus_a.dram_addr = 8'h06;
        @(negedge clk);
        tests_run++;
        if (perr_a !== EXP_PERR) begin
            fails++;
            $display("FAIL perr_set: proto_err %b, want %b", perr_a, EXP_PERR);
        end
        wait_ack(1'b0, "proto_rd05");
        idle(1'b0);
        repeat (3) @(negedge clk);
        tests_run++;
        if (perr_a !== EXP_PERR) begin
            fails++;
            $display("FAIL perr_sticky: proto_err %b, want %b", perr_a, EXP_PERR);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus_a.dram_cs = 1'b0; bus_a.dram_we = 1'b0; bus_a.dram_addr = '0; bus_a.dram_wdata = '0;
        bus_b.dram_cs = 1'b0; bus_b.dram_we = 1'b0; bus_b.dram_addr = '0; bus_b.dram_wdata = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_lat1();
        test_reset_abort();
        test_back_to_back();
        test_proto();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
